// File: rtl/ct_encrypt.sv
// ARC4 encryption engine: reads a length-prefixed plaintext, runs the ARC4
// key schedule and keystream generator against an external 256x8 S memory,
// and writes a length-prefixed ciphertext. pt_bad records any plaintext
// byte outside printable ASCII 0x20..0x7E.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | ready, rdy=1, waiting for en
// INIT     | S[i]=i, one write per cycle
// KRDI     | KSA: read S[i]
// KRDJ     | KSA: capture si, update j with key byte, read S[j]
// KWRI     | KSA: capture sj, write S[i]=sj
// KWRJ     | KSA: write S[j]=si, advance i and key byte index
// LRDL     | read plaintext length byte
// LWRL     | write ct[0]=L, set up keystream indices
// PRDI     | PRGA: i+1, read S[i+1]
// PRDJ     | PRGA: capture si, update j, read S[j]
// PWRI     | PRGA: capture sj, write S[i]=sj
// PWRJ     | PRGA: write S[j]=si
// PRDK     | PRGA: read S[si+sj] and pt[k]
// PWRC     | PRGA: write ct[k]=keystream^pt, check printable
module ct_encrypt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic        pt_bad,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren,
  output logic [7:0]  s_addr,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_INIT,
    ST_KRDI, ST_KRDJ, ST_KWRI, ST_KWRJ,
    ST_LRDL, ST_LWRL,
    ST_PRDI, ST_PRDJ, ST_PWRI, ST_PWRJ, ST_PRDK, ST_PWRC
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] key_q, key_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic [1:0]  kidx_q, kidx_d;
  logic        pt_bad_q, pt_bad_d;

  logic [7:0]  kb;
  logic [7:0]  i_inc;
  logic [7:0]  j_ksa;
  logic [7:0]  j_prga;
  logic        pt_out_of_range;

  // Key byte selection and index arithmetic (all mod 256)
  always_comb begin
    case (kidx_q)
      2'd0:    kb = key_q[23:16];
      2'd1:    kb = key_q[15:8];
      default: kb = key_q[7:0];
    endcase
    i_inc           = i_q + 8'd1;
    j_ksa           = j_q + s_rddata + kb;
    j_prga          = j_q + s_rddata;
    pt_out_of_range = (pt_rddata < 8'h20) || (pt_rddata > 8'h7E);
  end

  // State and datapath registers; async reset returns every output to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      key_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      len_q    <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      kidx_q   <= '0;
      pt_bad_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      len_q    <= len_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      kidx_q   <= kidx_d;
      pt_bad_q <= pt_bad_d;
    end
  end

  // Next-state and memory-port outputs, decoded from the current state
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    kidx_d    = kidx_q;
    pt_bad_d  = pt_bad_q;
    rdy       = 1'b0;
    pt_addr   = 8'd0;
    ct_addr   = 8'd0;
    ct_wrdata = 8'd0;
    ct_wren   = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          key_d    = key;
          pt_bad_d = 1'b0;
          i_d      = 8'd0;
          j_d      = 8'd0;
          kidx_d   = 2'd0;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: begin
        s_addr   = i_q;
        s_wrdata = i_q;
        s_wren   = 1'b1;
        i_d      = i_inc;
        if (i_q == 8'hFF) state_d = ST_KRDI;
      end
      ST_KRDI: begin
        s_addr  = i_q;
        state_d = ST_KRDJ;
      end
      ST_KRDJ: begin
        si_d    = s_rddata;
        j_d     = j_ksa;
        s_addr  = j_ksa;
        state_d = ST_KWRI;
      end
      ST_KWRI: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = ST_KWRJ;
      end
      ST_KWRJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        i_d      = i_inc;
        kidx_d   = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
        state_d  = (i_q == 8'hFF) ? ST_LRDL : ST_KRDI;
      end
      ST_LRDL: begin
        pt_addr = 8'd0;
        state_d = ST_LWRL;
      end
      ST_LWRL: begin
        ct_addr   = 8'd0;
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
        len_d     = pt_rddata;
        i_d       = 8'd0;
        j_d       = 8'd0;
        k_d       = 8'd1;
        state_d   = (pt_rddata == 8'd0) ? ST_IDLE : ST_PRDI;
      end
      ST_PRDI: begin
        i_d     = i_inc;
        s_addr  = i_inc;
        state_d = ST_PRDJ;
      end
      ST_PRDJ: begin
        si_d    = s_rddata;
        j_d     = j_prga;
        s_addr  = j_prga;
        state_d = ST_PWRI;
      end
      ST_PWRI: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = ST_PWRJ;
      end
      ST_PWRJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = ST_PRDK;
      end
      ST_PRDK: begin
        s_addr  = si_q + sj_q;
        pt_addr = k_q;
        state_d = ST_PWRC;
      end
      ST_PWRC: begin
        ct_addr   = k_q;
        ct_wrdata = s_rddata ^ pt_rddata;
        ct_wren   = 1'b1;
        if (pt_out_of_range) pt_bad_d = 1'b1;
        k_d       = k_q + 8'd1;
        state_d   = (k_q == len_q) ? ST_IDLE : ST_PRDI;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pt_bad = pt_bad_q;

endmodule

// File: tb/tb_ct_encrypt.sv
// Scoreboarded bench for ct_encrypt: behavioural memories, a plain ARC4
// reference model, and a monitor that checks every ciphertext write.
module tb_ct_encrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] key = '0;
  logic        rdy, pt_bad, ct_wren, s_wren;
  logic [7:0]  pt_addr, ct_addr, ct_wrdata, s_addr, s_wrdata;
  logic [7:0]  pt_rddata = '0;
  logic [7:0]  s_rddata = '0;

  logic [7:0]  pt_mem [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  s_mem  [256];
  logic [7:0]  ref_s  [256];
  logic [7:0]  ks     [256];

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] sb_q [$];
  logic [15:0] sb_exp;

  ct_encrypt dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .pt_bad(pt_bad),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories
  always @(posedge clk) begin
    pt_rddata <= pt_mem[pt_addr];
    s_rddata  <= s_mem[s_addr];
    if (s_wren)  s_mem[s_addr]   <= s_wrdata;
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  // Monitor: every ciphertext write must match the next expected entry
  always @(negedge clk) begin
    if (rst_n && ct_wren) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL ct_write_unexpected: got addr %0d data %h, required no write", ct_addr, ct_wrdata);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({ct_addr, ct_wrdata} !== sb_exp) begin
          n_fail++;
          $display("FAIL ct_write: got addr %0d data %h, required addr %0d data %h",
                   ct_addr, ct_wrdata, sb_exp[15:8], sb_exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  // Textbook ARC4: KSA over key bytes k[i mod 3], then keystream bytes 1..len
  task automatic ref_model(input logic [23:0] k, input int len);
    logic [7:0] kb [3];
    logic [7:0] i, j, t;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int n = 0; n < 256; n++) ref_s[n] = n[7:0];
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      j = j + ref_s[n] + kb[n % 3];
      t = ref_s[n];
      ref_s[n] = ref_s[j];
      ref_s[j] = t;
    end
    i = 8'd0;
    j = 8'd0;
    for (int n = 1; n <= len; n++) begin
      i = i + 8'd1;
      j = j + ref_s[i];
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
      t = ref_s[i] + ref_s[j];
      ks[n] = ref_s[t];
    end
  endtask

  task automatic load_random_pt(input int len);
    pt_mem[0] = len[7:0];
    for (int n = 1; n <= len; n++)
      pt_mem[n] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h20, 8'h7E))
                                              : 8'($urandom_range(0, 255));
  endtask

  task automatic do_run(input logic [23:0] k, input bit pulse_busy);
    int len, cycles, sdiff;
    bit bad;
    len = int'(pt_mem[0]);
    ref_model(k, len);
    bad = 1'b0;
    sb_q.push_back({8'd0, pt_mem[0]});
    for (int n = 1; n <= len; n++) begin
      sb_q.push_back({n[7:0], pt_mem[n] ^ ks[n]});
      if (pt_mem[n] < 8'h20 || pt_mem[n] > 8'h7E) bad = 1'b1;
    end
    for (int n = 0; n < 256; n++) s_mem[n] = 8'($urandom);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    key = 24'($urandom);
    cycles = 0;
    while (rdy == 1'b0 && cycles < 4000) begin
      cycles++;
      en = (pulse_busy && (cycles == 500 || cycles == 501)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    en = 1'b0;
    check("rdy_low_cycles", cycles, 1282 + 6 * len);
    check("ct_writes_outstanding", sb_q.size(), 0);
    sb_q.delete();
    check("pt_bad", {31'd0, pt_bad}, {31'd0, bad});
    sdiff = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== ref_s[n]) sdiff++;
    check("s_final_mismatches", sdiff, 0);
  endtask

  initial begin
    int rt_bad;
    for (int n = 0; n < 256; n++) begin
      pt_mem[n] = 8'($urandom);
      ct_mem[n] = 8'($urandom);
      s_mem[n]  = 8'($urandom);
    end

    #12;
    check("reset_outputs",
          {16'd0, rdy, pt_bad, ct_wren, s_wren, pt_addr | ct_addr | s_addr | ct_wrdata | s_wrdata, 4'd0},
          {16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // Empty message
    pt_mem[0] = 8'd0;
    do_run(24'h000000, 1'b0);

    // "hello" round trip
    pt_mem[0] = 8'd5;
    pt_mem[1] = "h"; pt_mem[2] = "e"; pt_mem[3] = "l"; pt_mem[4] = "l"; pt_mem[5] = "o";
    do_run(24'h1E4600, 1'b0);
    check("ct_len_byte", ct_mem[0], 5);
    rt_bad = 0;
    for (int n = 1; n <= 5; n++) if ((ct_mem[n] ^ ks[n]) !== pt_mem[n]) rt_bad++;
    check("roundtrip_mismatches", rt_bad, 0);

    // Non-printable, then printable clears pt_bad
    pt_mem[0] = 8'd3; pt_mem[1] = 8'h41; pt_mem[2] = 8'h0A; pt_mem[3] = 8'h42;
    do_run(24'h123456, 1'b0);
    pt_mem[0] = 8'd3; pt_mem[1] = "A"; pt_mem[2] = "B"; pt_mem[3] = "C";
    do_run(24'h123456, 1'b0);

    // Busy pulse and back-to-back runs on the same plaintext
    load_random_pt(10);
    do_run(24'h000001, 1'b1);
    do_run(24'h000002, 1'b0);

    // Full-length message
    load_random_pt(255);
    do_run(24'hFFFFFF, 1'b0);

    // Randomised runs, including printable-only boundary bytes
    for (int r = 0; r < 6; r++) begin
      load_random_pt($urandom_range(0, 30));
      if (r == 0) begin
        pt_mem[0] = 8'd2; pt_mem[1] = 8'h20; pt_mem[2] = 8'h7E;
      end
      if (r == 1) begin
        pt_mem[0] = 8'd2; pt_mem[1] = 8'h1F; pt_mem[2] = 8'h7F;
      end
      do_run(24'($urandom), 1'b0);
    end

    // Reset mid-KSA, then a fresh run
    pt_mem[0] = 8'd3; pt_mem[1] = 8'h41; pt_mem[2] = 8'h0A; pt_mem[3] = 8'h42;
    do_run(24'hABCDEF, 1'b0);
    @(negedge clk);
    key = 24'h010203;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    repeat (700) @(negedge clk);
    check("mid_ksa_busy", {31'd0, rdy}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {20'd0, rdy, pt_bad, ct_wren, s_wren, s_addr},
          {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    load_random_pt(7);
    do_run(24'h010203, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ct_encrypt.md
# ct_encrypt

ARC4 encryption engine: the producing end of the ciphertext memory that the key-search logic consumes. It takes a 24-bit key and a length-prefixed plaintext from a plaintext memory. It runs the ARC4 key schedule and keystream generator against an external 256-byte S memory, and writes a length-prefixed ciphertext into the ciphertext memory. It also flags plaintext bytes that fall outside the printable ASCII range the cracker accepts (0x20–0x7E), so that test messages are guaranteed crackable.

## Interface
Parameters: none. Key length is fixed at 3 bytes; memories are fixed at 256×8.
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  idle / ready to accept en
- key  in  24  encryption key, latched on accept; key byte 0 = key[23:16], byte 1 = key[15:8], byte 2 = key[7:0]
- pt_bad  out  1  at least one plaintext byte of the last message was outside 0x20..0x7E
- pt_addr  out  8  plaintext memory address
- pt_rddata  in  8  plaintext memory read data; synchronous, valid the cycle after the address is presented
- ct_addr  out  8  ciphertext memory address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write enable
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data; synchronous, 1-cycle latency
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable

## Operation
- Memory format: byte 0 = message length L (0..255); bytes 1..L = message. ct[0] is written with L.
- Accept: when rdy=1 and en=1 at a rising edge, latch key, clear pt_bad, clear i and j, and go to INIT. en is ignored while rdy=0.
- INIT (256 cycles): write S[i]=i for i=0..255.
- KSA (4 cycles per i, i=0..255):
  - RDI: s_addr=i.
  - RDJ: si←s_rddata; j←j+si+kb; s_addr=new j. kb is the key byte for i mod 3, tracked by a wrapping 0..2 counter (no divider).
  - WRI: sj←s_rddata; write S[i]=sj.
  - WRJ: write S[j]=si.
- LEN (2 cycles):
  - RDL: pt_addr=0.
  - WRL: L←pt_rddata; write ct[0]=L; clear i and j; set k=1.
- PRGA (6 cycles per byte k=1..L). Skipped when L=0.
  - RDI: i←i+1; s_addr=i+1.
  - RDJ: si←s_rddata; j←j+si; s_addr=new j.
  - WRI: sj←s_rddata; write S[i]=sj.
  - WRJ: write S[j]=si.
  - RDK: s_addr=si+sj (mod 256); pt_addr=k.
  - WRC: write ct[k]=s_rddata ^ pt_rddata; if pt_rddata<0x20 or >0x7E, set pt_bad; k←k+1. Leave PRGA after k=L.
- DONE → IDLE, with rdy=1.
- All 8-bit arithmetic is modulo 256 (i, j, and the index sums wrap). k never exceeds 255.
- pt_bad holds its value in IDLE until the next accept.

## Timing
- Reset values: rdy=1, pt_bad=0, every address output=0, ct_wrdata=0, s_wrdata=0, ct_wren=0, s_wren=0. FSM state is IDLE.
- rdy falls on the edge that accepts en. It is low for exactly 1282+6L cycles: INIT 256, KSA 1024, LEN 2, PRGA 6L. It returns to 1 on the following edge.
- Write enables are asserted for exactly one cycle per write, with address and data valid in that same cycle.
- Memory ordering:
  - A read issued in RDK sees the S writes made in WRI and WRJ of the same byte.
  - When i=j, the swap leaves S unchanged: WRI and WRJ both write si.
- Reset mid-operation: every output returns immediately to its reset value. Memory contents are left partial and are not cleaned up. The next accept fully re-initialises S.
- The block imposes no assumption on the prior contents of S.

## Test plan
- Reset: assert rst_n=0 mid-KSA → rdy=1, pt_bad=0, ct_wren=0, s_wren=0 asynchronously; a fresh en then completes normally.
- Empty message: L=0, key=24'h000000 → ct[0]=0, no other ct writes, rdy low 1282 cycles. S contents match the software KSA for key 00 00 00.
- Round trip: key=24'h1E4600, pt="hello" (L=5) → rdy low 1312 cycles. ct bytes 1..5 match the software ARC4 model, and ct[0]=5. Running the existing arc4 on this ct with the same key yields "hello". pt_bad=0.
- Non-printable: pt = L=3, bytes 0x41 0x0A 0x42 → pt_bad=1 after completion, all 3 ct bytes still written correctly. A second run on "ABC" clears pt_bad to 0.
- Busy and back-to-back: pulse en during KSA → no effect on the cycle count. Two consecutive runs with keys 24'h000001 then 24'h000002 on the same pt → each ct matches the model (S re-initialised between runs).
- Wrap: L=255 with key=24'hFFFFFF → 255 ct bytes, with final ct_addr=255. i and j wrap correctly (match the model). rdy low 2812 cycles.
